// File: rtl/conv2_window_gen.sv
// Purpose: builds 3x3 valid-mode windows from a raster pixel stream for the conv2 data_in port.
// Latency: a window appears exactly 1 cycle after the pixel that completes it.
// Backpressure: none; every pix_valid cycle is accepted, idle cycles leave all state unchanged.
module conv2_window_gen #(
    parameter int DATA_W = 32,  // pixel word width
    parameter int IMG_W  = 14,  // pixels per image row
    parameter int IMG_H  = 14   // rows per frame
) (
    input  logic              clk,
    input  logic              rst_n,      // synchronous, active-high despite the name
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] win_out [0:2][0:2],
    output logic              win_valid,
    output logic              frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]     col_q, col_d, pos_col;
    logic [RW-1:0]     row_q, row_d, pos_row;
    logic [DATA_W-1:0] lb0_q [IMG_W];           // previous row
    logic [DATA_W-1:0] lb1_q [IMG_W];           // row before the previous one
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic [DATA_W-1:0] sh_q [0:2][0:2];         // free-running column shift register
    logic [DATA_W-1:0] sh_d [0:2][0:2];
    logic [DATA_W-1:0] win_q [0:2][0:2];        // registered output window
    logic              win_valid_q, frame_done_q;
    logic              emit, last;

    // Effective pixel position (sof overrides the counters) and line-buffer reads at that column.
    always_comb begin
        pos_col = sof ? '0 : col_q;
        pos_row = sof ? '0 : row_q;
        lb0_rd  = lb0_q[pos_col];
        lb1_rd  = lb1_q[pos_col];
        emit    = pix_valid && (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
        last    = emit && (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    end

    // Raster counters: column wraps into the next row, last row wraps into the next frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_valid) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
            end else begin
                col_d = pos_col + CW'(1);
                row_d = pos_row;
            end
        end
    end

    // Next shift-register contents: drop the left column, append the new right column.
    always_comb begin
        sh_d = sh_q;
        for (int r = 0; r < 3; r++) begin
            sh_d[r][0] = sh_q[r][1];
            sh_d[r][1] = sh_q[r][2];
        end
        sh_d[0][2] = lb1_rd;
        sh_d[1][2] = lb0_rd;
        sh_d[2][2] = pix_in;
    end

    // Data storage without reset: stale contents are masked by the x>=2 / y>=2 window gating.
    always_ff @(posedge clk) begin
        if (pix_valid && !rst_n) begin
            lb0_q[pos_col] <= pix_in;
            lb1_q[pos_col] <= lb0_rd;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    sh_q[r][c] <= sh_d[r][c];
                end
            end
        end
    end

    // Control state and output registers; the window only updates when a new one is emitted.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= emit;
            frame_done_q <= last;
            if (emit) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        win_q[r][c] <= sh_d[r][c];
                    end
                end
            end
        end
    end

    assign win_out    = win_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv2_window_gen.sv
// Directed bench: 4x4 instance driven from a vector table plus corner sequences,
// and a default-size 14x14 instance driven with one full frame.
module tb_conv2_window_gen;
    typedef struct {
        logic        rst;
        logic        vld;
        logic        sof;
        logic [31:0] pix;
        logic        exp_wv;
        logic        exp_fd;
        logic [31:0] exp_tl;   // top-left value of the expected window (4x4 stream, value y*4+x)
    } vec_t;

    logic        clk;
    logic        rst4, vld4, sof4, wv4, fd4;
    logic [31:0] pix4;
    logic [31:0] win4 [0:2][0:2];
    logic        rst14, vld14, sof14, wv14, fd14;
    logic [31:0] pix14;
    logic [31:0] win14 [0:2][0:2];

    logic [31:0] exp_win [0:2][0:2];
    int          tests, fails;
    int          wcnt4, fcnt4;

    conv2_window_gen #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) dut4 (
        .clk(clk), .rst_n(rst4), .pix_in(pix4), .pix_valid(vld4), .sof(sof4),
        .win_out(win4), .win_valid(wv4), .frame_done(fd4)
    );

    conv2_window_gen dut14 (
        .clk(clk), .rst_n(rst14), .pix_in(pix14), .pix_valid(vld14), .sof(sof14),
        .win_out(win14), .win_valid(wv14), .frame_done(fd14)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    task automatic check_win4(input string nm);
        int bad;
        logic [31:0] a, e;
        bad = 0; a = 0; e = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (win4[r][c] !== exp_win[r][c]) begin
                    if (bad == 0) begin a = win4[r][c]; e = exp_win[r][c]; end
                    bad++;
                end
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s win_out: %0d words wrong, first got %0d expected %0d", nm, bad, a, e);
        end
    endtask

    // Drive one vector into the 4x4 instance, update the expected window, compare.
    task automatic apply4(input vec_t v, input string nm);
        rst4 = v.rst; vld4 = v.vld; sof4 = v.sof; pix4 = v.pix;
        @(posedge clk);
        #1;
        if (v.rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) exp_win[r][c] = 32'd0;
        end else if (v.exp_wv) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) exp_win[r][c] = v.exp_tl + 32'(4 * r + c);
        end
        check({nm, " win_valid"}, 32'(wv4), 32'(v.exp_wv));
        check({nm, " frame_done"}, 32'(fd4), 32'(v.exp_fd));
        check_win4(nm);
        if (wv4 === 1'b1) wcnt4++;
        if (fd4 === 1'b1) fcnt4++;
        rst4 = 1'b0; vld4 = 1'b0; sof4 = 1'b0;
    endtask

    vec_t base_tbl [16];
    vec_t v;
    vec_t idle_v;
    vec_t rst_v;

    initial begin
        tests = 0; fails = 0; wcnt4 = 0; fcnt4 = 0;
        rst4 = 1'b1; vld4 = 1'b0; sof4 = 1'b0; pix4 = '0;
        rst14 = 1'b1; vld14 = 1'b0; sof14 = 1'b0; pix14 = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) exp_win[r][c] = 32'd0;

        //            rst vld sof pix wv fd tl
        base_tbl = '{ '{0, 1, 1,  0, 0, 0, 0},
                      '{0, 1, 0,  1, 0, 0, 0},
                      '{0, 1, 0,  2, 0, 0, 0},
                      '{0, 1, 0,  3, 0, 0, 0},
                      '{0, 1, 0,  4, 0, 0, 0},
                      '{0, 1, 0,  5, 0, 0, 0},
                      '{0, 1, 0,  6, 0, 0, 0},
                      '{0, 1, 0,  7, 0, 0, 0},
                      '{0, 1, 0,  8, 0, 0, 0},
                      '{0, 1, 0,  9, 0, 0, 0},
                      '{0, 1, 0, 10, 1, 0, 0},
                      '{0, 1, 0, 11, 1, 0, 1},
                      '{0, 1, 0, 12, 0, 0, 0},
                      '{0, 1, 0, 13, 0, 0, 0},
                      '{0, 1, 0, 14, 1, 0, 4},
                      '{0, 1, 0, 15, 1, 1, 5} };
        idle_v = '{0, 0, 1, 999, 0, 0, 0};   // sof without pix_valid must be ignored
        rst_v  = '{1, 0, 0, 0, 0, 0, 0};

        // Reset state
        apply4(rst_v, "reset0");
        apply4(rst_v, "reset1");
        rst14 = 1'b0;

        // Basic 4x4 frame
        wcnt4 = 0; fcnt4 = 0;
        for (int i = 0; i < 16; i++) apply4(base_tbl[i], "basic");
        check("basic windows", 32'(wcnt4), 32'd4);
        check("basic frame_done", 32'(fcnt4), 32'd1);

        // Gapped input: every pixel followed by an idle cycle
        wcnt4 = 0; fcnt4 = 0;
        for (int i = 0; i < 16; i++) begin
            apply4(base_tbl[i], "gap_pix");
            apply4(idle_v, "gap_idle");
        end
        check("gapped windows", 32'(wcnt4), 32'd4);
        check("gapped frame_done", 32'(fcnt4), 32'd1);

        // Back-to-back frames, second one offset by 100 and without sof
        for (int f = 0; f < 2; f++) begin
            wcnt4 = 0; fcnt4 = 0;
            for (int i = 0; i < 16; i++) begin
                v = base_tbl[i];
                v.pix = v.pix + 32'(100 * f);
                if (v.exp_wv) v.exp_tl = v.exp_tl + 32'(100 * f);
                if (f == 1) v.sof = 1'b0;
                apply4(v, "b2b");
            end
            check("b2b windows", 32'(wcnt4), 32'd4);
            check("b2b frame_done", 32'(fcnt4), 32'd1);
        end

        // Early sof: at old (2,1) and at window-completing old (2,2)
        for (int k = 9; k <= 10; k++) begin
            wcnt4 = 0; fcnt4 = 0;
            for (int i = 0; i < k; i++) begin
                v = '{0, 1, (i == 0), 32'(200 + i), 0, 0, 0};
                apply4(v, "early_old");
            end
            check("early old windows", 32'(wcnt4), 32'd0);
            for (int i = 0; i < 16; i++) apply4(base_tbl[i], "early_new");
            check("early new windows", 32'(wcnt4), 32'd4);
            check("early frame_done", 32'(fcnt4), 32'd1);
        end

        // Reset mid-frame after pixel 9, then a full frame without sof
        for (int i = 0; i < 10; i++) apply4(base_tbl[i], "mid_pre");
        apply4(rst_v, "mid_reset");
        wcnt4 = 0; fcnt4 = 0;
        for (int i = 0; i < 16; i++) begin
            v = base_tbl[i];
            v.sof = 1'b0;
            apply4(v, "post_reset");
        end
        check("post_reset windows", 32'(wcnt4), 32'd4);

        // Default 14x14 frame on the second instance
        begin
            int nw, nf, bad;
            nw = 0; nf = 0;
            for (int y = 0; y < 14; y++) begin
                for (int x = 0; x < 14; x++) begin
                    pix14 = 32'(y * 14 + x); vld14 = 1'b1; sof14 = (y == 0 && x == 0);
                    @(posedge clk);
                    #1;
                    vld14 = 1'b0; sof14 = 1'b0;
                    if (wv14 === 1'b1) nw++;
                    if (fd14 === 1'b1) nf++;
                    if (y >= 2 && x >= 2) begin
                        bad = 0;
                        for (int r = 0; r < 3; r++)
                            for (int c = 0; c < 3; c++)
                                if (win14[r][c] !== 32'((y - 2 + r) * 14 + (x - 2 + c))) bad++;
                        check("w14 window words wrong", 32'(bad), 32'd0);
                    end
                end
            end
            check("w14 windows", 32'(nw), 32'd144);
            check("w14 frame_done", 32'(nf), 32'd1);
            @(posedge clk);
            #1;
            check("w14 held valid", 32'(wv14), 32'd0);
            bad = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    if (win14[r][c] !== 32'((11 + r) * 14 + 11 + c)) bad++;
            check("w14 last window words wrong", 32'(bad), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
